// File: rtl/vp_pkg.sv
// Shared vector-processor sizing and word type, reused by the register file,
// load/store unit and vector memory.
package vp_pkg;
  localparam int unsigned VEC_WIDTH  = 512;
  localparam int unsigned MEM_DEPTH  = 512;
  localparam int unsigned MEM_ADDR_W = 9;

  typedef logic [VEC_WIDTH-1:0] vec_word_t;
endpackage

// File: rtl/mem_array.sv
// Word storage for the vector memory: one synchronous write port, a
// combinational read tap, and a synchronous whole-array clear.
module mem_array
  import vp_pkg::*;
#(
  parameter int unsigned WIDTH  = VEC_WIDTH,
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] read_address,
  output logic [WIDTH-1:0]  read_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reset wins over a same-cycle write, so a pending write is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_W'(i)] <= '0;
      end
    end else if (write_enable) begin
      mem[write_address] <= data;
    end
  end

  // Pre-edge contents feed the output register, giving read-before-write.
  assign read_data = mem[read_address];

endmodule

// File: rtl/memory.sv
// Vector load/store memory: 512 x 512-bit words, one write and one
// registered read per clock, synchronous active-high clear.
module memory
  import vp_pkg::*;
#(
  parameter int unsigned WIDTH  = VEC_WIDTH,
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] read_address,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  out
);

  logic [WIDTH-1:0] read_data;

  mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .write_address(write_address),
    .data         (data),
    .read_address (read_address),
    .read_data    (read_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (read_enable) begin
      out <= read_data;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios followed by random
// traffic, all compared against an array-based reference model.
module tb_memory;
  import vp_pkg::*;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            write_enable = 1'b0;
  logic            read_enable = 1'b0;
  logic [8:0]      read_address = '0;
  logic [8:0]      write_address = '0;
  logic [511:0]    data = '0;
  logic [511:0]    out;

  logic [511:0]    model [512];
  logic [511:0]    exp_out;
  logic [511:0]    ones;
  int unsigned     n_checks = 0;
  int unsigned     n_fail = 0;

  always #5 clk = ~clk;

  memory #(
    .WIDTH (512),
    .DEPTH (512),
    .ADDR_W(9)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_address (read_address),
    .write_address(write_address),
    .data         (data),
    .out          (out)
  );

  task automatic check(input string tag, input logic [511:0] expected);
    n_checks++;
    assert (out === expected) else begin
      n_fail++;
      $error("FAIL %s: out=%h expected=%h", tag, out, expected);
    end
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: drive on the falling edge, update the model at the rising
  // edge (read sees pre-write contents), then compare just after it.
  task automatic step(input logic rst, input logic we, input int unsigned wa,
                      input logic [511:0] d, input logic re, input int unsigned ra,
                      input string tag);
    @(negedge clk);
    reset         = rst;
    write_enable  = we;
    write_address = wa[8:0];
    data          = d;
    read_enable   = re;
    read_address  = ra[8:0];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 512; i++) model[i] = '0;
      exp_out = '0;
    end else begin
      if (re) exp_out = model[ra];
      if (we) model[wa] = d;
    end
    #1 check(tag, exp_out);
  endtask

  initial begin
    ones = '1;
    for (int i = 0; i < 512; i++) model[i] = 'x;
    exp_out = 'x;

    step(1, 0, 0, '0, 0, 0, "reset");
    check("reset_out_zero", 512'd0);

    step(0, 0, 0, '0, 1, 10, "read10_after_reset");
    check("read10_zero", 512'd0);

    step(0, 1, 10, 512'd120, 0, 0, "write10_120");
    step(0, 0, 0, '0, 1, 10, "read10_120");
    check("read10_is_120", 512'd120);

    step(0, 1, 10, 512'd15, 0, 0, "write10_15");
    step(0, 0, 0, '0, 1, 10, "read10_15");
    check("read10_is_15", 512'd15);

    // reset with a write pending: the write must be dropped
    step(1, 1, 10, 512'd99, 1, 10, "reset_mid_op");
    check("reset_mid_out_zero", 512'd0);
    step(0, 0, 0, '0, 1, 10, "read10_post_reset");
    check("read10_post_reset_zero", 512'd0);

    step(0, 1, 3, 512'h55, 0, 0, "write3_55");
    step(0, 1, 3, 512'hAA, 1, 3, "rbw_same_cycle");
    check("rbw_old_value", 512'h55);
    step(0, 0, 0, '0, 1, 3, "read3_after_rbw");
    check("rbw_new_value", 512'hAA);

    step(0, 1, 0, ones, 0, 0, "write0_ones");
    step(0, 1, 511, ones, 0, 0, "write511_ones");
    step(0, 0, 0, '0, 1, 0, "read0");
    check("addr0_ones", ones);
    step(0, 0, 0, '0, 1, 1, "read1");
    check("addr1_zero", 512'd0);
    step(0, 0, 0, '0, 1, 511, "read511");
    check("addr511_ones", ones);
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 20 + c, rand_word(), 0, 1, "hold");
      check("hold_ones", ones);
    end

    // random traffic concentrated on a few addresses to force collisions
    for (int n = 0; n < 400; n++) begin
      int unsigned wa, ra;
      wa = ($urandom_range(0, 9) == 0) ? 511 : $urandom_range(0, 15);
      ra = ($urandom_range(0, 9) == 0) ? 511 : $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ra = wa;
      step(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1, wa,
           rand_word(), $urandom_range(0, 1) == 1, ra, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
